ssd1306_spi_receiver: RTL and testbench

Receive-side model of the SSD1306 4-wire SPI interface, driven by `ssd1306_driver` pins inside the same clock domain. It deserialises SCLK/SDIN under CS#, classifies each byte as command or data using D/C#, and decodes the command subset the driver's power-on sequence uses into a shadow configuration. Data bytes go to a 128x32 framebuffer write port with SSD1306 address auto-increment. It serves as the display-side endpoint for loopback simulation and on-chip capture of what the driver actually sent.

---
 rtl/ssd1306_spi_receiver_pkg.sv | 36 +++
 rtl/ssd1306_spi_receiver_deserializer.sv | 71 +++++++
 rtl/ssd1306_spi_receiver.sv | 218 +++++++++++++++++++++
 tb/tb_ssd1306_spi_receiver.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd1306_spi_receiver_pkg.sv
// Shared constants for the SSD1306 SPI receiver: opcodes, reset values, addressing modes, parser states.
package ssd1306_spi_receiver_pkg;

    localparam logic [7:0] OP_DISPLAY_OFF  = 8'hAE;
    localparam logic [7:0] OP_DISPLAY_ON   = 8'hAF;
    localparam logic [7:0] OP_SEG_REMAP0   = 8'hA0;
    localparam logic [7:0] OP_SEG_REMAP1   = 8'hA1;
    localparam logic [7:0] OP_COM_SCAN_INC = 8'hC0;
    localparam logic [7:0] OP_COM_SCAN_DEC = 8'hC8;
    localparam logic [7:0] OP_CONTRAST     = 8'h81;
    localparam logic [7:0] OP_CHARGE_PUMP  = 8'h8D;
    localparam logic [7:0] OP_PRECHARGE    = 8'hD9;
    localparam logic [7:0] OP_COM_PINS     = 8'hDA;
    localparam logic [7:0] OP_ADDR_MODE    = 8'h20;

    localparam logic [1:0] ADDR_HORIZONTAL = 2'b00;
    localparam logic [1:0] ADDR_VERTICAL   = 2'b01;
    localparam logic [1:0] ADDR_PAGE       = 2'b10;
    localparam logic [1:0] ADDR_INVALID    = 2'b11;

    localparam logic [7:0] RST_CONTRAST  = 8'h7F;
    localparam logic [7:0] RST_PRECHARGE = 8'h22;
    localparam logic [7:0] RST_COM_PINS  = 8'h12;

    typedef enum logic {
        ST_OPCODE = 1'b0,
        ST_ARG    = 1'b1
    } parser_state_e;

    // Opcodes whose following command byte is an argument.
    function automatic logic takes_arg(input logic [7:0] op);
        return (op == OP_CONTRAST) || (op == OP_CHARGE_PUMP) || (op == OP_PRECHARGE) ||
               (op == OP_COM_PINS) || (op == OP_ADDR_MODE);
    endfunction

endpackage

// File: rtl/ssd1306_spi_receiver_deserializer.sv
// SPI mode-0 byte deserializer: pin synchronisers, SCLK/CS# edge detect, shift register, bit counter.
// Byte strobes are combinational so the parent can register them on the third clk after the pin edge.
module ssd1306_spi_receiver_deserializer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       sclk,
    input  logic       sdin,
    input  logic       dc,
    input  logic       res_n,
    output logic       clear_c,
    output logic       byte_valid_c,
    output logic [7:0] byte_c,
    output logic       is_data_c,
    output logic       protocol_error_c
);

    logic [1:0] cs_sync;
    logic [1:0] sclk_sync;
    logic [1:0] sdin_sync;
    logic [1:0] dc_sync;
    logic [1:0] res_sync;
    logic       cs_prev;
    logic       sclk_prev;
    logic [6:0] shift;
    logic [2:0] bit_cnt;
    logic       sclk_edge;
    logic       cs_rise;

    // An edge in the same cycle CS# is seen rising still counts (cs_prev low).
    assign sclk_edge = sclk_sync[1] && !sclk_prev && (!cs_sync[1] || !cs_prev);
    assign cs_rise   = cs_sync[1] && !cs_prev;

    assign clear_c          = rst || !res_sync[1];
    assign byte_valid_c     = !clear_c && sclk_edge && (bit_cnt == 3'd7);
    assign byte_c           = {shift, sdin_sync[1]};
    assign is_data_c        = dc_sync[1];
    assign protocol_error_c = !clear_c && cs_rise && (bit_cnt != 3'd0) && !byte_valid_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync   <= 2'b11;
            sclk_sync <= 2'b00;
            sdin_sync <= 2'b00;
            dc_sync   <= 2'b00;
            res_sync  <= 2'b00;
            cs_prev   <= 1'b1;
            sclk_prev <= 1'b0;
            shift     <= 7'd0;
            bit_cnt   <= 3'd0;
        end else begin
            cs_sync   <= {cs_sync[0], cs};
            sclk_sync <= {sclk_sync[0], sclk};
            sdin_sync <= {sdin_sync[0], sdin};
            dc_sync   <= {dc_sync[0], dc};
            res_sync  <= {res_sync[0], res_n};
            cs_prev   <= cs_sync[1];
            sclk_prev <= sclk_sync[1];
            if (clear_c) begin
                shift   <= 7'd0;
                bit_cnt <= 3'd0;
            end else if (sclk_edge) begin
                shift   <= byte_c[6:0];
                bit_cnt <= bit_cnt + 3'd1;
            end else if (cs_rise) begin
                bit_cnt <= 3'd0;
            end
        end
    end

endmodule

// File: rtl/ssd1306_spi_receiver.sv
// SSD1306 4-wire SPI display-side endpoint: command parser, shadow configuration and framebuffer
// write port with auto-incrementing address pointer.
module ssd1306_spi_receiver
    import ssd1306_spi_receiver_pkg::*;
#(
    parameter int unsigned COLUMNS = 128,
    parameter int unsigned PAGES   = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                ssd1306_cs,
    input  logic                                ssd1306_sclk,
    input  logic                                ssd1306_sdin,
    input  logic                                ssd1306_dc,
    input  logic                                ssd1306_reset,
    output logic                                byte_valid,
    output logic                                byte_is_data,
    output logic [7:0]                          byte_out,
    output logic                                fb_we,
    output logic [$clog2(COLUMNS*PAGES)-1:0]    fb_addr,
    output logic [7:0]                          fb_data,
    output logic                                display_on,
    output logic                                charge_pump_en,
    output logic                                seg_remap,
    output logic                                com_scan_rev,
    output logic [7:0]                          contrast,
    output logic [7:0]                          precharge,
    output logic [7:0]                          com_pins,
    output logic [1:0]                          addr_mode,
    output logic                                protocol_error
);

    localparam int unsigned AW = $clog2(COLUMNS * PAGES);
    localparam int unsigned CW = $clog2(COLUMNS);
    localparam int unsigned PW = (PAGES > 1) ? $clog2(PAGES) : 1;

    logic          clear_c;
    logic          dser_valid_c;
    logic [7:0]    dser_byte_c;
    logic          dser_is_data_c;
    logic          dser_error_c;

    parser_state_e state_q, state_d;
    logic [7:0]    opcode_q, opcode_d;
    logic [CW-1:0] col_q, col_d, col_next;
    logic [PW-1:0] page_q, page_d, page_next;

    logic          byte_valid_d, byte_is_data_d, fb_we_d, protocol_error_d;
    logic [7:0]    byte_out_d, fb_data_d;
    logic [AW-1:0] fb_addr_d;
    logic          display_on_d, charge_pump_en_d, seg_remap_d, com_scan_rev_d;
    logic [7:0]    contrast_d, precharge_d, com_pins_d;
    logic [1:0]    addr_mode_d;
    logic          last_col, last_page;

    ssd1306_spi_receiver_deserializer u_deser (
        .clk              (clk),
        .rst              (rst),
        .cs               (ssd1306_cs),
        .sclk             (ssd1306_sclk),
        .sdin             (ssd1306_sdin),
        .dc               (ssd1306_dc),
        .res_n            (ssd1306_reset),
        .clear_c          (clear_c),
        .byte_valid_c     (dser_valid_c),
        .byte_c           (dser_byte_c),
        .is_data_c        (dser_is_data_c),
        .protocol_error_c (dser_error_c)
    );

    assign last_col  = (col_q == CW'(COLUMNS - 1));
    assign last_page = (page_q == PW'(PAGES - 1));

    // Pointer position following a framebuffer write in the current addressing mode.
    always_comb begin
        col_next  = col_q;
        page_next = page_q;
        case (addr_mode)
            ADDR_HORIZONTAL: begin
                if (last_col) begin
                    col_next  = '0;
                    page_next = last_page ? '0 : page_q + PW'(1);
                end else begin
                    col_next = col_q + CW'(1);
                end
            end
            ADDR_VERTICAL: begin
                if (last_page) begin
                    page_next = '0;
                    col_next  = last_col ? '0 : col_q + CW'(1);
                end else begin
                    page_next = page_q + PW'(1);
                end
            end
            default: col_next = last_col ? '0 : col_q + CW'(1);
        endcase
    end

    // Parser next-state, configuration decode and framebuffer write generation.
    always_comb begin
        state_d          = state_q;
        opcode_d         = opcode_q;
        col_d            = col_q;
        page_d           = page_q;
        byte_valid_d     = 1'b0;
        byte_is_data_d   = byte_is_data;
        byte_out_d       = byte_out;
        fb_we_d          = 1'b0;
        fb_addr_d        = fb_addr;
        fb_data_d        = fb_data;
        protocol_error_d = dser_error_c;
        display_on_d     = display_on;
        charge_pump_en_d = charge_pump_en;
        seg_remap_d      = seg_remap;
        com_scan_rev_d   = com_scan_rev;
        contrast_d       = contrast;
        precharge_d      = precharge;
        com_pins_d       = com_pins;
        addr_mode_d      = addr_mode;

        if (dser_valid_c) begin
            byte_valid_d   = 1'b1;
            byte_is_data_d = dser_is_data_c;
            byte_out_d     = dser_byte_c;
            if (dser_is_data_c) begin
                fb_we_d   = 1'b1;
                fb_addr_d = AW'(page_q) * AW'(COLUMNS) + AW'(col_q);
                fb_data_d = dser_byte_c;
                col_d     = col_next;
                page_d    = page_next;
                if (state_q == ST_ARG) begin
                    protocol_error_d = 1'b1;
                    state_d          = ST_OPCODE;
                end
            end else begin
                case (state_q)
                    ST_OPCODE: begin
                        case (dser_byte_c)
                            OP_DISPLAY_OFF:  display_on_d   = 1'b0;
                            OP_DISPLAY_ON:   display_on_d   = 1'b1;
                            OP_SEG_REMAP0:   seg_remap_d    = 1'b0;
                            OP_SEG_REMAP1:   seg_remap_d    = 1'b1;
                            OP_COM_SCAN_INC: com_scan_rev_d = 1'b0;
                            OP_COM_SCAN_DEC: com_scan_rev_d = 1'b1;
                            default: begin
                                if (takes_arg(dser_byte_c)) begin
                                    opcode_d = dser_byte_c;
                                    state_d  = ST_ARG;
                                end
                            end
                        endcase
                    end
                    ST_ARG: begin
                        case (opcode_q)
                            OP_CONTRAST:    contrast_d       = dser_byte_c;
                            OP_CHARGE_PUMP: charge_pump_en_d = dser_byte_c[2];
                            OP_PRECHARGE:   precharge_d      = dser_byte_c;
                            OP_COM_PINS:    com_pins_d       = dser_byte_c;
                            OP_ADDR_MODE: begin
                                if (dser_byte_c[1:0] != ADDR_INVALID) begin
                                    addr_mode_d = dser_byte_c[1:0];
                                end
                            end
                            default: ;
                        endcase
                        state_d = ST_OPCODE;
                    end
                    default: state_d = ST_OPCODE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear_c) begin
            state_q        <= ST_OPCODE;
            opcode_q       <= 8'd0;
            col_q          <= '0;
            page_q         <= '0;
            byte_valid     <= 1'b0;
            byte_is_data   <= 1'b0;
            byte_out       <= 8'd0;
            fb_we          <= 1'b0;
            fb_addr        <= '0;
            fb_data        <= 8'd0;
            protocol_error <= 1'b0;
            display_on     <= 1'b0;
            charge_pump_en <= 1'b0;
            seg_remap      <= 1'b0;
            com_scan_rev   <= 1'b0;
            contrast       <= RST_CONTRAST;
            precharge      <= RST_PRECHARGE;
            com_pins       <= RST_COM_PINS;
            addr_mode      <= ADDR_PAGE;
        end else begin
            state_q        <= state_d;
            opcode_q       <= opcode_d;
            col_q          <= col_d;
            page_q         <= page_d;
            byte_valid     <= byte_valid_d;
            byte_is_data   <= byte_is_data_d;
            byte_out       <= byte_out_d;
            fb_we          <= fb_we_d;
            fb_addr        <= fb_addr_d;
            fb_data        <= fb_data_d;
            protocol_error <= protocol_error_d;
            display_on     <= display_on_d;
            charge_pump_en <= charge_pump_en_d;
            seg_remap      <= seg_remap_d;
            com_scan_rev   <= com_scan_rev_d;
            contrast       <= contrast_d;
            precharge      <= precharge_d;
            com_pins       <= com_pins_d;
            addr_mode      <= addr_mode_d;
        end
    end

endmodule

// File: tb/tb_ssd1306_spi_receiver.sv
// Directed bench for ssd1306_spi_receiver: SPI byte driver, expected-byte queue drained by a monitor.
module tb_ssd1306_spi_receiver;

    localparam int unsigned HALF = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs, sclk, sdin, dc, res_n;
    logic       byte_valid, byte_is_data, fb_we, protocol_error;
    logic [7:0] byte_out, fb_data, contrast, precharge, com_pins;
    logic [8:0] fb_addr;
    logic       display_on, charge_pump_en, seg_remap, com_scan_rev;
    logic [1:0] addr_mode;

    typedef struct {
        logic [7:0] b;
        logic       dc;
        int         addr;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   err_seen = 0;

    always #5 clk = ~clk;

    ssd1306_spi_receiver dut (
        .clk            (clk),
        .rst            (rst),
        .ssd1306_cs     (cs),
        .ssd1306_sclk   (sclk),
        .ssd1306_sdin   (sdin),
        .ssd1306_dc     (dc),
        .ssd1306_reset  (res_n),
        .byte_valid     (byte_valid),
        .byte_is_data   (byte_is_data),
        .byte_out       (byte_out),
        .fb_we          (fb_we),
        .fb_addr        (fb_addr),
        .fb_data        (fb_data),
        .display_on     (display_on),
        .charge_pump_en (charge_pump_en),
        .seg_remap      (seg_remap),
        .com_scan_rev   (com_scan_rev),
        .contrast       (contrast),
        .precharge      (precharge),
        .com_pins       (com_pins),
        .addr_mode      (addr_mode),
        .protocol_error (protocol_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard drain: every byte strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (protocol_error === 1'b1) err_seen++;
            if (byte_valid === 1'b1) begin
                if (q.size() == 0) begin
                    check("byte_valid_unexpected", 32'(byte_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("byte_out", 32'(byte_out), 32'(e.b));
                    check("byte_is_data", 32'(byte_is_data), 32'(e.dc));
                    check("fb_we", 32'(fb_we), 32'(e.dc));
                    if (e.dc) begin
                        check("fb_addr", 32'(fb_addr), 32'(e.addr));
                        check("fb_data", 32'(fb_data), 32'(e.b));
                    end
                end
            end else if (fb_we === 1'b1) begin
                check("fb_we_without_byte", 32'(fb_we), 32'd0);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Full byte under its own CS# window; also checks the strobe lands on the 3rd clk edge.
    task automatic send_byte(input logic [7:0] b, input logic is_data, input int addr);
        exp_t e;
        e.b = b; e.dc = is_data; e.addr = addr;
        q.push_back(e);
        cs = 1'b0; dc = is_data;
        wait_clk(HALF);
        for (int i = 7; i >= 0; i--) begin
            sdin = b[i]; sclk = 1'b0;
            wait_clk(HALF);
            sclk = 1'b1;
            if (i == 0) begin
                wait_clk(2);
                check("latency_early", 32'(byte_valid), 32'd0);
                wait_clk(1);
                check("latency_edge3", 32'(byte_valid), 32'd1);
            end else begin
                wait_clk(HALF);
            end
        end
        sclk = 1'b0;
        wait_clk(HALF);
        cs = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic send_partial(input logic [7:0] b, input int n, input logic release_cs);
        cs = 1'b0; dc = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < n; i++) begin
            sdin = b[7-i]; sclk = 1'b0;
            wait_clk(HALF);
            sclk = 1'b1;
            wait_clk(HALF);
        end
        sclk = 1'b0;
        wait_clk(HALF);
        if (release_cs) begin
            cs = 1'b1;
            wait_clk(HALF + 4);
        end
    endtask

    task automatic pulse_res();
        res_n = 1'b0;
        wait_clk(4);
        res_n = 1'b1;
        wait_clk(4);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".display_on"}, 32'(display_on), 32'd0);
        check({tag, ".contrast"}, 32'(contrast), 32'h7F);
        check({tag, ".precharge"}, 32'(precharge), 32'h22);
        check({tag, ".com_pins"}, 32'(com_pins), 32'h12);
        check({tag, ".charge_pump_en"}, 32'(charge_pump_en), 32'd0);
        check({tag, ".seg_remap"}, 32'(seg_remap), 32'd0);
        check({tag, ".com_scan_rev"}, 32'(com_scan_rev), 32'd0);
        check({tag, ".addr_mode"}, 32'(addr_mode), 32'd2);
        check({tag, ".strobes"}, {29'd0, byte_valid, fb_we, protocol_error}, 32'd0);
    endtask

    function automatic logic [7:0] pattern(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    initial begin
        logic [7:0] por [$];
        int         err0;

        por = '{8'hAE, 8'hD5, 8'h80, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'hDA, 8'h00,
                8'h81, 8'h0F, 8'h20, 8'h00, 8'hA0, 8'hC0, 8'hAF};
        rst = 1'b1; cs = 1'b1; sclk = 1'b0; sdin = 1'b0; dc = 1'b0; res_n = 1'b1;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(4);
        check_reset_state("reset");

        // Contrast command with argument.
        send_byte(8'h81, 1'b0, 0);
        check("contrast_before_arg", 32'(contrast), 32'h7F);
        send_byte(8'h3C, 1'b0, 0);
        check("contrast_set", 32'(contrast), 32'h3C);

        // Driver power-on sequence.
        foreach (por[i]) send_byte(por[i], 1'b0, 0);
        check("por.display_on", 32'(display_on), 32'd1);
        check("por.contrast", 32'(contrast), 32'h0F);
        check("por.charge_pump_en", 32'(charge_pump_en), 32'd1);
        check("por.precharge", 32'(precharge), 32'hF1);
        check("por.com_pins", 32'(com_pins), 32'h00);
        check("por.addr_mode", 32'(addr_mode), 32'd0);
        check("por.seg_remap", 32'(seg_remap), 32'd0);
        check("por.com_scan_rev", 32'(com_scan_rev), 32'd0);

        // Horizontal mode: 513 writes wrap from 511 back to 0.
        for (int i = 0; i < 513; i++) send_byte(pattern(i), 1'b1, i % 512);

        // Page mode: column wraps inside page 0.
        pulse_res();
        send_byte(8'h20, 1'b0, 0);
        send_byte(8'h02, 1'b0, 0);
        check("page.addr_mode", 32'(addr_mode), 32'd2);
        for (int i = 0; i < 130; i++) send_byte(pattern(i), 1'b1, i % 128);

        // Vertical mode plus ignored mode 11.
        pulse_res();
        send_byte(8'h20, 1'b0, 0);
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'h20, 1'b0, 0);
        send_byte(8'h03, 1'b0, 0);
        check("vert.addr_mode_kept", 32'(addr_mode), 32'd1);
        send_byte(8'h11, 1'b1, 0);
        send_byte(8'h22, 1'b1, 128);
        send_byte(8'h33, 1'b1, 256);
        send_byte(8'h44, 1'b1, 384);
        send_byte(8'h55, 1'b1, 1);

        // CS# released after 5 bits.
        pulse_res();
        err0 = err_seen;
        send_partial(8'hFF, 5, 1'b1);
        check("cs_abort.error_pulses", 32'(err_seen - err0), 32'd1);
        send_byte(8'hAF, 1'b0, 0);
        check("cs_abort.display_on", 32'(display_on), 32'd1);

        // Data byte where an argument was expected.
        pulse_res();
        err0 = err_seen;
        send_byte(8'h81, 1'b0, 0);
        send_byte(8'h55, 1'b1, 0);
        check("data_in_arg.error_pulses", 32'(err_seen - err0), 32'd1);
        check("data_in_arg.contrast", 32'(contrast), 32'h7F);
        send_byte(8'h81, 1'b0, 0);
        send_byte(8'h40, 1'b0, 0);
        check("data_in_arg.recovered", 32'(contrast), 32'h40);

        // RES# low mid-byte and mid-argument.
        send_byte(8'hAF, 1'b0, 0);
        send_byte(8'hA1, 1'b0, 0);
        send_byte(8'hD9, 1'b0, 0);
        err0 = err_seen;
        send_partial(8'hC8, 4, 1'b0);
        pulse_res();
        cs = 1'b1;
        wait_clk(HALF + 4);
        check_reset_state("res_mid_byte");
        check("res_mid_byte.error_pulses", 32'(err_seen - err0), 32'd0);
        send_byte(8'h81, 1'b0, 0);
        send_byte(8'h3C, 1'b0, 0);
        check("res_mid_byte.fsm_opcode", 32'(contrast), 32'h3C);
        check("res_mid_byte.precharge", 32'(precharge), 32'h22);

        wait_clk(8);
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
